// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the input PIO slave.
// Register map offsets and the edge-capture selector.
package soc_system_pio_pkg;

  localparam logic [1:0] DATA    = 2'd0;
  localparam logic [1:0] RSVD    = 2'd1;
  localparam logic [1:0] IRQMASK = 2'd2;
  localparam logic [1:0] EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    RISE = 2'd0,
    FALL = 2'd1,
    ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One-bit debounce filter between synchronizer and stable value.
// Only instantiated when SOC_SYSTEM_PIO_IN_DEBOUNCE_EN is defined.
module soc_system_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic armed,
  input  logic sync,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (!armed) begin
      cnt    <= '0;
      stable <= sync;
    end else if (sync == stable) begin
      cnt    <= '0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      stable <= sync;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soc_system_pio_in.sv
// Avalon-MM input PIO: sync, optional debounce, edge capture, irq.
// Debounce compiled in with SOC_SYSTEM_PIO_IN_DEBOUNCE_EN.
module soc_system_pio_in
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam edge_type_e ETYPE = edge_type_e'(EDGE_TYPE);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      rd_mux;

  assign armed = (arm_cnt == 2'd3);
  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & write_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      arm_cnt <= '0;
    end else begin
      sync1   <= in_port;
      sync2   <= sync1;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end
  end

`ifdef SOC_SYSTEM_PIO_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    soc_system_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .armed (armed),
      .sync  (sync2[i]),
      .stable(stable[i])
    );
  end
`else
  localparam int unused_db = DEBOUNCE_CYCLES;
  assign stable = sync2;
`endif

  // Until armed, prev tracks the synchronizer so held inputs never look like edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= armed ? stable : sync2;
  end

  always_comb begin
    edges = '0;
    unique case (1'b1)
      ETYPE == FALL: edges = prev & ~stable;
      ETYPE == ANY:  edges = prev ^ stable;
      default:       edges = stable & ~prev;
    endcase
    if (!armed) edges = '0;
  end

  always_comb begin
    clr = '0;
    if (wr_en && address == EDGECAP) clr = writedata[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr_en && address == IRQMASK) irqmask <= writedata[WIDTH-1:0];
      edgecap <= (edgecap & ~clr) | edges;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      DATA:    rd_mux = 32'(stable);
      IRQMASK: rd_mux = 32'(irqmask);
      EDGECAP: rd_mux = 32'(edgecap);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
    else            readdata <= '0;
  end

  assign irq = |(edgecap & irqmask);

  if (WIDTH < 32) begin : g_unused
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

endmodule
